traffic_light_sequencer: RTL and testbench

TRAFFIC_LIGHT_SEQUENCER -- requirements
Module: traffic_light_sequencer

---
 rtl/traffic_light_sequencer.sv | 175 +++++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// Traffic light sequencer: timed ALL_RED/GREEN/YELLOW/RED cycle driven by an external tick,
// with pedestrian-shortened green, a walk indication during red, and a maintenance flash mode.
module traffic_light_sequencer #(
    parameter int unsigned TICKS_ALL_RED   = 2,
    parameter int unsigned TICKS_GREEN     = 20,
    parameter int unsigned TICKS_GREEN_MIN = 5,
    parameter int unsigned TICKS_YELLOW    = 4,
    parameter int unsigned TICKS_RED       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_request,
    input  logic       flash_mode,
    output logic       red_signal,
    output logic       yellow_signal,
    output logic       green_signal,
    output logic       ped_walk,
    output logic [2:0] state_out,
    output logic [7:0] ticks_left
);

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_RED     = 3'd3,
        ST_FLASH   = 3'd4
    } state_e;

    localparam logic [7:0] T_ALL_RED  = 8'(TICKS_ALL_RED);
    localparam logic [7:0] T_GREEN    = 8'(TICKS_GREEN);
    localparam logic [7:0] T_YELLOW   = 8'(TICKS_YELLOW);
    localparam logic [7:0] T_RED      = 8'(TICKS_RED);
    // A pending pedestrian may end green once at least TICKS_GREEN_MIN ticks have elapsed.
    localparam logic [7:0] PED_CUTOFF = 8'(TICKS_GREEN - TICKS_GREEN_MIN + 1);

    state_e     state_q, state_d;
    logic [7:0] ticks_q, ticks_d;
    logic       ped_pending_q, pending_d;
    logic       ped_walk_q, walk_d;
    logic       blink_q, blink_d;
    logic       red_q, red_d;
    logic       yellow_q, yellow_d;
    logic       green_q, green_d;

    logic       expire_s;
    logic       req_seen_s;
    logic [7:0] count_s;

    assign expire_s   = tick & (ticks_q <= 8'd1);
    assign req_seen_s = ped_pending_q | ped_request;
    assign count_s    = tick ? (ticks_q - 8'd1) : ticks_q;

    // Next-state, timer, pedestrian and blink logic plus lamp decode of the next state.
    always_comb begin
        state_d   = state_q;
        ticks_d   = ticks_q;
        pending_d = ped_pending_q;
        walk_d    = ped_walk_q;
        blink_d   = blink_q;
        if (flash_mode) begin
            state_d   = ST_FLASH;
            ticks_d   = 8'd0;
            pending_d = 1'b0;
            walk_d    = 1'b0;
            if (state_q != ST_FLASH) begin
                blink_d = 1'b1;
            end else if (tick) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    pending_d = req_seen_s;
                    if (expire_s) begin
                        state_d = ST_GREEN;
                        ticks_d = T_GREEN;
                    end else begin
                        ticks_d = count_s;
                    end
                end
                ST_GREEN: begin
                    pending_d = req_seen_s;
                    if (expire_s || (tick && ped_pending_q && (ticks_q <= PED_CUTOFF))) begin
                        state_d = ST_YELLOW;
                        ticks_d = T_YELLOW;
                    end else begin
                        ticks_d = count_s;
                    end
                end
                ST_YELLOW: begin
                    if (expire_s) begin
                        state_d   = ST_RED;
                        ticks_d   = T_RED;
                        walk_d    = req_seen_s;
                        pending_d = 1'b0;
                    end else begin
                        ticks_d   = count_s;
                        pending_d = req_seen_s;
                    end
                end
                ST_RED: begin
                    pending_d = req_seen_s;
                    if (expire_s) begin
                        state_d = ST_GREEN;
                        ticks_d = T_GREEN;
                        walk_d  = 1'b0;
                    end else begin
                        ticks_d = count_s;
                    end
                end
                ST_FLASH: begin
                    state_d   = ST_ALL_RED;
                    ticks_d   = T_ALL_RED;
                    pending_d = 1'b0;
                    walk_d    = 1'b0;
                    blink_d   = 1'b0;
                end
                default: begin
                    state_d   = ST_ALL_RED;
                    ticks_d   = T_ALL_RED;
                    pending_d = req_seen_s;
                    walk_d    = 1'b0;
                    blink_d   = 1'b0;
                end
            endcase
        end

        red_d    = 1'b0;
        yellow_d = 1'b0;
        green_d  = 1'b0;
        case (state_d)
            ST_ALL_RED: red_d    = 1'b1;
            ST_RED:     red_d    = 1'b1;
            ST_GREEN:   green_d  = 1'b1;
            ST_YELLOW:  yellow_d = 1'b1;
            ST_FLASH:   yellow_d = blink_d;
            default:    red_d    = 1'b1;
        endcase
    end

    // State, timer and registered outputs, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ALL_RED;
            ticks_q       <= T_ALL_RED;
            ped_pending_q <= 1'b0;
            ped_walk_q    <= 1'b0;
            blink_q       <= 1'b0;
            red_q         <= 1'b1;
            yellow_q      <= 1'b0;
            green_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ticks_q       <= ticks_d;
            ped_pending_q <= pending_d;
            ped_walk_q    <= walk_d;
            blink_q       <= blink_d;
            red_q         <= red_d;
            yellow_q      <= yellow_d;
            green_q       <= green_d;
        end
    end

    assign red_signal    = red_q;
    assign yellow_signal = yellow_q;
    assign green_signal  = green_q;
    assign ped_walk      = ped_walk_q;
    assign state_out     = state_q;
    assign ticks_left    = ticks_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer: a driver applies directed and random stimulus and
// queues the response of an elapsed-tick reference model; a monitor pops and compares every cycle.
module tb_traffic_light_sequencer;

    localparam int ALL_RED_T = 2;
    localparam int GREEN_T   = 20;
    localparam int GREEN_MIN = 5;
    localparam int YELLOW_T  = 4;
    localparam int RED_T     = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ped_request = 1'b0;
    logic       flash_mode = 1'b0;
    logic       red_signal, yellow_signal, green_signal, ped_walk;
    logic [2:0] state_out;
    logic [7:0] ticks_left;

    traffic_light_sequencer #(
        .TICKS_ALL_RED  (ALL_RED_T),
        .TICKS_GREEN    (GREEN_T),
        .TICKS_GREEN_MIN(GREEN_MIN),
        .TICKS_YELLOW   (YELLOW_T),
        .TICKS_RED      (RED_T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .ped_request  (ped_request),
        .flash_mode   (flash_mode),
        .red_signal   (red_signal),
        .yellow_signal(yellow_signal),
        .green_signal (green_signal),
        .ped_walk     (ped_walk),
        .state_out    (state_out),
        .ticks_left   (ticks_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] tl;
        logic       r;
        logic       y;
        logic       g;
        logic       w;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: phase number plus ticks elapsed in that phase.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_pending = 1'b0;
    bit m_walk    = 1'b0;
    bit m_blink   = 1'b0;

    function automatic int dur_of(input int ph);
        case (ph)
            0:       return ALL_RED_T;
            1:       return GREEN_T;
            2:       return YELLOW_T;
            3:       return RED_T;
            default: return 0;
        endcase
    endfunction

    function automatic int next_of(input int ph);
        case (ph)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit p, input bit f);
        bit seen;
        bit ends;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_pending = 1'b0; m_walk = 1'b0; m_blink = 1'b0;
        end else if (f) begin
            if (m_phase != 4) m_blink = 1'b1;
            else if (t) m_blink = ~m_blink;
            m_phase = 4; m_elapsed = 0; m_pending = 1'b0; m_walk = 1'b0;
        end else if (m_phase == 4) begin
            m_phase = 0; m_elapsed = 0; m_blink = 1'b0;
        end else begin
            seen = m_pending | p;
            ends = t && ((m_elapsed + 1 >= dur_of(m_phase)) ||
                         (m_phase == 1 && m_pending && m_elapsed + 1 >= GREEN_MIN));
            if (ends) begin
                if (m_phase == 2) begin
                    m_walk = seen; m_pending = 1'b0;
                end else begin
                    m_pending = seen;
                    if (m_phase == 3) m_walk = 1'b0;
                end
                m_phase = next_of(m_phase);
                m_elapsed = 0;
            end else begin
                m_pending = seen;
                if (t) m_elapsed++;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_phase);
        o.tl = (m_phase == 4) ? 8'd0 : 8'(dur_of(m_phase) - m_elapsed);
        o.r  = (m_phase == 0) || (m_phase == 3);
        o.g  = (m_phase == 1);
        o.y  = (m_phase == 2) || (m_phase == 4 && m_blink);
        o.w  = m_walk;
        return o;
    endfunction

    task automatic apply(input bit r, input bit t, input bit p, input bit f);
        @(negedge clk);
        reset = r; tick = t; ped_request = p; flash_mode = f;
        model_step(r, t, p, f);
        exp_q.push_back(model_obs());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Monitor: compare the DUT outputs after every edge against the oldest queued expectation.
    always @(posedge clk) begin
        obs_t got;
        obs_t want;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{state_out, ticks_left, red_signal, yellow_signal, green_signal, ped_walk};
            n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL outputs vec %0d: got st=%0d tl=%0d r=%0b y=%0b g=%0b walk=%0b, want st=%0d tl=%0d r=%0b y=%0b g=%0b walk=%0b",
                         n_vec, got.st, got.tl, got.r, got.y, got.g, got.w,
                         want.st, want.tl, want.r, want.y, want.g, want.w);
            end
        end
    end

    initial begin
        bit flash_lvl;
        int wait_cnt;
        // Reset, then two ticks through ALL_RED into GREEN, then a free-running full period and more.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        ticks(2 * (GREEN_T + YELLOW_T + RED_T) + 3);

        // Pedestrian request after the 2nd green tick shortens green to the minimum.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        ticks(2);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(GREEN_T + YELLOW_T + RED_T);

        // Request after the 10th green tick, then a request coincident with RED entry.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        ticks(10);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        ticks(YELLOW_T - 1);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5);

        // Flash raised mid-RED, blink for a few ticks, then drop back through ALL_RED.
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b1);
            apply(1'b0, 1'b0, 1'b0, 1'b1);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(4);

        // Reset together with a tick mid-YELLOW.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2 + GREEN_T + 2);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(3);

        // Randomized traffic with occasional flash episodes and resets.
        flash_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) flash_lvl = ~flash_lvl;
            apply($urandom_range(0, 799) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0,
                  flash_lvl);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
